// File: rtl/num_conv_pkg.sv
// Shared mode encoding for the numeric width converter.
package num_conv_pkg;

    localparam int unsigned ModeW = 2;

    typedef enum logic [ModeW-1:0] {
        ModeWrap = 2'b00,
        ModeSat  = 2'b01,
        ModeZext = 2'b10,
        ModeRsvd = 2'b11
    } conv_mode_e;

endpackage

// File: rtl/num_conv_fifo2.sv
// Two-entry valid/ready buffer; in_ready_o depends only on registered occupancy.
module num_conv_fifo2 #(
    parameter int unsigned Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign out_data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Clearing storage makes the idle output read as zero after reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/num_width_converter.sv
// Converts samples between widths (wrap / saturate / zero-extend) into a 2-entry
// output buffer, and counts accepted samples that were clamped.
module num_width_converter
    import num_conv_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic             in_signed_i,
    input  logic [ModeW-1:0] mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_sat_o,
    input  logic             clear_cnt_i,
    output logic [CNT_W-1:0] sat_count_o
);

    // 66 signed bits hold any 64-bit signed or unsigned value plus the clamp limits.
    localparam int unsigned XW = 66;
    localparam logic signed [XW-1:0] One  = 66'sd1;
    localparam logic signed [XW-1:0] SMax = (One <<< (OUT_W - 1)) - One;
    localparam logic signed [XW-1:0] SMin = -(One <<< (OUT_W - 1));
    localparam logic signed [XW-1:0] UMax = (One <<< OUT_W) - One;

    conv_mode_e             mode;
    logic                   sext;
    logic signed [XW-1:0]   ext;
    logic signed [XW-1:0]   hi;
    logic signed [XW-1:0]   lo;
    logic [OUT_W-1:0]       conv_data;
    logic                   conv_sat;
    logic                   sat_push;
    logic [CNT_W-1:0]       cnt_q;

    always_comb begin
        mode      = conv_mode_e'(mode_i);
        sext      = in_signed_i && (mode != ModeZext);
        ext       = {{(XW - IN_W){sext & in_data_i[IN_W-1]}}, in_data_i};
        hi        = in_signed_i ? SMax : UMax;
        lo        = in_signed_i ? SMin : '0;
        conv_data = ext[OUT_W-1:0];
        conv_sat  = 1'b0;
        if (mode == ModeSat) begin
            if (ext > hi) begin
                conv_data = hi[OUT_W-1:0];
                conv_sat  = 1'b1;
            end else if (ext < lo) begin
                conv_data = lo[OUT_W-1:0];
                conv_sat  = 1'b1;
            end
        end
    end

    assign sat_push = in_valid_i & in_ready_o & conv_sat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_cnt_i) begin
            cnt_q <= sat_push ? CNT_W'(1) : '0;
        end else if (sat_push && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign sat_count_o = cnt_q;

    num_conv_fifo2 #(
        .Width(OUT_W + 1)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  ({conv_sat, conv_data}),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o ({out_sat_o, out_data_o})
    );

endmodule

// File: tb/tb_num_width_converter.sv
// Directed checks of the width converter: narrowing, widening, counter saturation.
module tb_num_width_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_signed;
    logic [1:0]  mode;
    logic        out_ready;
    logic        clear_cnt;

    logic        in_ready, out_valid, out_sat;
    logic [7:0]  out_data;
    logic [15:0] sat_count;

    logic        c_in_ready, c_out_valid, c_out_sat;
    logic [7:0]  c_out_data;
    logic [1:0]  c_sat_count;

    logic        w_in_valid, w_in_signed;
    logic [7:0]  w_in_data;
    logic [1:0]  w_mode;
    logic        w_in_ready, w_out_valid, w_out_sat;
    logic [15:0] w_out_data;
    logic [15:0] w_sat_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    num_width_converter #(.IN_W(16), .OUT_W(8), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_signed_i(in_signed), .mode_i(mode),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_sat_o(out_sat), .clear_cnt_i(clear_cnt), .sat_count_o(sat_count)
    );

    num_width_converter #(.IN_W(16), .OUT_W(8), .CNT_W(2)) u_cnt (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(c_in_ready),
        .in_data_i(in_data), .in_signed_i(in_signed), .mode_i(mode),
        .out_valid_o(c_out_valid), .out_ready_i(out_ready), .out_data_o(c_out_data),
        .out_sat_o(c_out_sat), .clear_cnt_i(clear_cnt), .sat_count_o(c_sat_count)
    );

    num_width_converter #(.IN_W(8), .OUT_W(16), .CNT_W(16)) u_wide (
        .clk_i(clk), .rst_i(rst), .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
        .in_data_i(w_in_data), .in_signed_i(w_in_signed), .mode_i(w_mode),
        .out_valid_o(w_out_valid), .out_ready_i(1'b1), .out_data_o(w_out_data),
        .out_sat_o(w_out_sat), .clear_cnt_i(1'b0), .sat_count_o(w_sat_count)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic [1:0]  m;
        logic [7:0]  ed;
        logic        es;
    } vec_t;

    typedef struct packed {
        logic [7:0]  d;
        logic        s;
        logic [1:0]  m;
        logic [15:0] ed;
    } wvec_t;

    vec_t  vecs [12];
    wvec_t wvecs [4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_data   = v.d;
        in_signed = v.s;
        mode      = v.m;
    endtask

    initial begin
        vecs[0]  = '{16'h8AD0, 1'b1, 2'b01, 8'h80, 1'b1};
        vecs[1]  = '{16'h8AD0, 1'b1, 2'b00, 8'hD0, 1'b0};
        vecs[2]  = '{16'hFFFF, 1'b0, 2'b01, 8'hFF, 1'b1};
        vecs[3]  = '{16'h0064, 1'b1, 2'b01, 8'h64, 1'b0};
        vecs[4]  = '{16'h012C, 1'b0, 2'b00, 8'h2C, 1'b0};
        vecs[5]  = '{16'h8AD0, 1'b1, 2'b11, 8'hD0, 1'b0};
        vecs[6]  = '{16'h8AD0, 1'b1, 2'b10, 8'hD0, 1'b0};
        vecs[7]  = '{16'h00C8, 1'b1, 2'b01, 8'h7F, 1'b1};
        vecs[8]  = '{16'hFF80, 1'b1, 2'b01, 8'h80, 1'b0};
        vecs[9]  = '{16'hFF7F, 1'b1, 2'b01, 8'h80, 1'b1};
        vecs[10] = '{16'h00FF, 1'b0, 2'b01, 8'hFF, 1'b0};
        vecs[11] = '{16'h0100, 1'b0, 2'b01, 8'hFF, 1'b1};
        wvecs[0] = '{8'h9C, 1'b1, 2'b00, 16'hFF9C};
        wvecs[1] = '{8'h9C, 1'b1, 2'b10, 16'h009C};
        wvecs[2] = '{8'h9C, 1'b0, 2'b00, 16'h009C};
        wvecs[3] = '{8'h9C, 1'b1, 2'b01, 16'hFF9C};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; mode = 2'b00;
        out_ready = 1'b1; clear_cnt = 1'b0;
        w_in_valid = 1'b0; w_in_data = '0; w_in_signed = 1'b0; w_mode = 2'b00;
        step(); step();
        rst = 1'b0;
        step();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_sat_count", 64'(sat_count), 64'd0);
        check_eq("rst_out_data",  64'(out_data),  64'd0);
        check_eq("rst_out_sat",   64'(out_sat),   64'd0);

        // Single-sample conversions, one-cycle latency.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            step();
            in_valid = 1'b0;
            check_eq($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            check_eq($sformatf("v%0d_data", i),  64'(out_data),  64'(vecs[i].ed));
            check_eq($sformatf("v%0d_sat", i),   64'(out_sat),   64'(vecs[i].es));
            if (i == 0) check_eq("v0_count", 64'(sat_count), 64'd1);
            step();
        end
        check_eq("count_after_table", 64'(sat_count), 64'd5);
        check_eq("count_sticky_cnt2", 64'(c_sat_count), 64'd3);

        // Clear together with a saturating acceptance, then clear alone.
        drive(vecs[0]);
        clear_cnt = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("clear_sat_cnt2", 64'(c_sat_count), 64'd1);
        check_eq("clear_sat_cnt16", 64'(sat_count), 64'd1);
        step();
        check_eq("clear_alone", 64'(sat_count), 64'd0);
        clear_cnt = 1'b0;
        step();

        // Back-to-back burst at full throughput.
        for (int i = 1; i <= 3; i++) begin
            drive('{16'(i), 1'b0, 2'b00, 8'h00, 1'b0});
            step();
            check_eq($sformatf("burst%0d_data", i), 64'(out_data), 64'(i));
            check_eq($sformatf("burst%0d_ready", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check_eq("burst_drained", 64'(out_valid), 64'd0);

        // Backpressure: third sample refused, first held stable.
        out_ready = 1'b0;
        drive('{16'h0011, 1'b0, 2'b00, 8'h00, 1'b0});
        step();
        check_eq("bp_ready1", 64'(in_ready), 64'd1);
        drive('{16'h0022, 1'b0, 2'b00, 8'h00, 1'b0});
        step();
        check_eq("bp_ready2", 64'(in_ready), 64'd0);
        drive('{16'h0033, 1'b0, 2'b00, 8'h00, 1'b0});
        step();
        step();
        check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
        check_eq("bp_hold_data",  64'(out_data),  64'h11);
        check_eq("bp_hold_ready", 64'(in_ready),  64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("bp_drain1", 64'(out_data), 64'h11);
        step();
        check_eq("bp_drain2_valid", 64'(out_valid), 64'd1);
        check_eq("bp_drain2", 64'(out_data), 64'h22);
        step();
        check_eq("bp_empty", 64'(out_valid), 64'd0);

        // Reset with two buffered samples and a sample offered during reset.
        out_ready = 1'b0;
        drive(vecs[0]);
        step();
        step();
        in_valid = 1'b0;
        check_eq("pre_rst_count", 64'(sat_count), 64'd2);
        check_eq("pre_rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        drive(vecs[0]);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_ready", 64'(in_ready),  64'd1);
        check_eq("mid_rst_count", 64'(sat_count), 64'd0);
        check_eq("mid_rst_data",  64'(out_data),  64'd0);
        step();
        check_eq("mid_rst_noaccept", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        // Widening instance.
        for (int i = 0; i < 4; i++) begin
            w_in_valid  = 1'b1;
            w_in_data   = wvecs[i].d;
            w_in_signed = wvecs[i].s;
            w_mode      = wvecs[i].m;
            step();
            w_in_valid = 1'b0;
            check_eq($sformatf("w%0d_valid", i), 64'(w_out_valid), 64'd1);
            check_eq($sformatf("w%0d_data", i),  64'(w_out_data),  64'(wvecs[i].ed));
            check_eq($sformatf("w%0d_sat", i),   64'(w_out_sat),   64'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/num_width_converter.md
NUM_WIDTH_CONVERTER -- requirements
Module: num_width_converter

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, meaning input sample width in bits (legal: 2..64).
REQ-002 The block SHALL have parameter OUT_W, default 8, meaning output sample width in bits (legal: 2..64, any relation to IN_W).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning width of the saturation event counter.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid_i, input, 1 bit: input sample present.
REQ-007 The block SHALL have port in_ready_o, output, 1 bit: block can accept a sample.
REQ-008 The block SHALL have port in_data_i, input, IN_W bits: input sample.
REQ-009 The block SHALL have port in_signed_i, input, 1 bit: 1 = in_data_i is two's complement, 0 = unsigned.
REQ-010 The block SHALL have port mode_i, input, 2 bits: 00 WRAP, 01 SAT, 10 ZEXT, 11 reserved.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit: output sample present.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts the sample.
REQ-013 The block SHALL have port out_data_o, output, OUT_W bits: converted sample.
REQ-014 The block SHALL have port out_sat_o, output, 1 bit: the current output sample was clamped.
REQ-015 The block SHALL have port clear_cnt_i, input, 1 bit: synchronous clear of sat_count_o.
REQ-016 The block SHALL have port sat_count_o, output, CNT_W bits: number of clamped samples accepted.

Function
REQ-017 The block SHALL accept a sample on a cycle where in_valid_i and in_ready_o are both 1, capturing in_data_i, in_signed_i and mode_i together.
REQ-018 The block SHALL buffer converted samples in a 2-entry FIFO, with in_ready_o = 1 exactly when the registered occupancy is less than 2, so in_ready_o has no combinational path from out_ready_i.
REQ-019 The block SHALL present a sample accepted in cycle N on out_valid_o in cycle N+1 when the FIFO was empty, giving 1-cycle latency and 1 sample/cycle throughput while out_ready_i = 1.
REQ-020 The block SHALL hold out_data_o, out_sat_o and out_valid_o stable while out_valid_o = 1 and out_ready_i = 0.
REQ-021 The block SHALL allow a push and a pop in the same cycle when occupancy is 1, leaving occupancy at 1.
REQ-022 In WRAP mode, the block SHALL sign-extend (signed input) or zero-extend (unsigned input) when OUT_W >= IN_W, keep the low OUT_W bits when OUT_W < IN_W, and set out_sat_o = 0.
REQ-023 In SAT mode with a signed input, the block SHALL clamp the result to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-024 In SAT mode with an unsigned input, the block SHALL clamp the result to [0, 2^OUT_W-1].
REQ-025 In SAT mode, the block SHALL set out_sat_o = 1 only when clamping changed the value.
REQ-026 In ZEXT mode, the block SHALL treat the input as unsigned regardless of in_signed_i, zero-extend or truncate it, and set out_sat_o = 0.
REQ-027 The block SHALL treat mode 11 as WRAP.
REQ-028 The block SHALL increment sat_count_o by 1 on acceptance of a sample that will have out_sat_o = 1, and the counter SHALL stick at 2^CNT_W-1 without wrapping.
REQ-029 When clear_cnt_i and a saturating acceptance occur in the same cycle, the block SHALL set sat_count_o to 1; clear alone SHALL set it to 0.

Reset
REQ-030 rst_i = 1 at a rising clk_i edge SHALL set FIFO occupancy to 0, out_valid_o to 0, in_ready_o to 1 on the following cycle, sat_count_o to 0, out_data_o to 0 and out_sat_o to 0.
REQ-031 Reset asserted mid-stream SHALL discard any buffered samples without a handshake, and a sample presented during reset SHALL NOT be accepted.

Structure
REQ-032 The mode enum (WRAP, SAT, ZEXT, RSVD) and the 2-bit mode width constant SHALL reside in package num_conv_pkg.
REQ-033 The 2-entry buffer SHALL be a sub-module num_conv_fifo2, parametrised on payload width (OUT_W+1).
REQ-034 The conversion logic SHALL be combinational ahead of the FIFO write, and SHALL be the only place where widths differ.

Verification (IN_W=16, OUT_W=8 unless stated)
REQ-035 Signed -30000 (0x8AD0), SAT -> out_data_o 0x80, out_sat_o 1, sat_count_o 1; same input in WRAP -> 0xD0, out_sat_o 0.
REQ-036 Unsigned 0xFFFF, SAT -> 0xFF with sat 1; signed 100, SAT -> 0x64 with sat 0; unsigned 300, WRAP -> 0x2C.
REQ-037 IN_W=8, OUT_W=16: signed 0x9C (-100), WRAP -> 0xFF9C; the same input in ZEXT -> 0x009C.
REQ-038 Backpressure: with out_ready_i = 0 and 3 valid samples offered, 2 are accepted and in_ready_o = 0; releasing out_ready_i drains the samples in order with no loss or duplication.
REQ-039 With CNT_W=2, 5 saturating samples -> sat_count_o sticks at 3; clear_cnt_i together with a 6th saturating sample -> 1.
REQ-040 Reset asserted with 2 samples buffered -> next cycle out_valid_o 0, in_ready_o 1, sat_count_o 0.
